// File: rtl/period_detector.sv
// period_detector: recovers the wave length (in samples) of a signed square or saw
// stream from rising zero crossings with hysteresis, and flags a stable pitch.
//
// Ports:
//   clk               - system clock, rising edge
//   reset_n           - asynchronous active-low reset
//   sample_valid      - sample is consumed on cycles where this is 1
//   sample            - signed audio sample, SAMPLE_WIDTH bits
//   wave_length       - last measured period in samples
//   wave_length_valid - 1-cycle pulse, wave_length updated
//   locked            - two consecutive periods matched within TOLERANCE
//   timeout           - 1-cycle pulse, no rising crossing for MAX_PERIOD samples
module period_detector #(
    parameter int          SAMPLE_WIDTH = 32,
    parameter int unsigned HYSTERESIS   = 4096,
    parameter int unsigned MAX_PERIOD   = 65535,
    parameter int unsigned TOLERANCE    = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic [31:0]             wave_length,
    output logic                    wave_length_valid,
    output logic                    locked,
    output logic                    timeout
);

    typedef enum logic [1:0] {
        LVL_UNKNOWN = 2'd0,
        LVL_HIGH    = 2'd1,
        LVL_LOW     = 2'd2
    } level_t;

    typedef enum logic {
        ST_SEEK    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam logic signed [SAMPLE_WIDTH-1:0] HYST_P =
        SAMPLE_WIDTH'(HYSTERESIS);
    localparam logic signed [SAMPLE_WIDTH-1:0] HYST_N = -HYST_P;
    localparam logic [31:0] MAX_P = MAX_PERIOD;
    localparam logic [31:0] TOL   = TOLERANCE;

    state_t      r_state;
    level_t      r_level;
    logic [31:0] r_count;
    logic [31:0] r_prev;
    logic [31:0] r_wave_length;
    logic        r_wlv;
    logic        r_locked;
    logic        r_timeout;

    state_t      w_state_next;
    level_t      w_level_next;
    logic [31:0] w_count_next;
    logic [31:0] w_count_inc;
    logic [31:0] w_diff;
    logic        w_above;
    logic        w_below;
    logic        w_rise;
    logic        w_match;
    logic        w_report;
    logic        w_expire;
    logic        w_locked_next;

    // Level tracker; the in-band region holds the previous level, so an
    // UNKNOWN start can never produce a crossing.
    always_comb begin
        w_above      = $signed(sample) > HYST_P;
        w_below      = $signed(sample) < HYST_N;
        w_level_next = r_level;
        if (sample_valid) begin
            if (w_above) begin
                w_level_next = LVL_HIGH;
            end else if (w_below) begin
                w_level_next = LVL_LOW;
            end
        end
        w_rise = sample_valid && (r_level == LVL_LOW) && w_above;
    end

    // State register: FSM state plus the datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_SEEK;
            r_level       <= LVL_UNKNOWN;
            r_count       <= 32'd0;
            r_prev        <= 32'd0;
            r_wave_length <= 32'd0;
            r_wlv         <= 1'b0;
            r_locked      <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_level   <= w_level_next;
            r_count   <= w_count_next;
            r_wlv     <= w_report;
            r_timeout <= w_expire;
            r_locked  <= w_locked_next;
            if (w_report) begin
                r_wave_length <= r_count;
                r_prev        <= r_count;
            end
        end
    end

    // Next-state logic. A crossing on the same sample that would reach
    // MAX_PERIOD takes priority over the timeout.
    always_comb begin
        w_count_inc  = r_count + 32'd1;
        w_state_next = r_state;
        w_count_next = r_count;
        if (sample_valid) begin
            case (r_state)
                ST_SEEK: begin
                    if (w_rise) begin
                        w_state_next = ST_MEASURE;
                        w_count_next = 32'd1;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        w_count_next = 32'd1;
                    end else if (w_count_inc == MAX_P) begin
                        w_count_next = 32'd0;
                        w_state_next = ST_SEEK;
                    end else begin
                        w_count_next = w_count_inc;
                    end
                end
                default: begin
                    w_state_next = ST_SEEK;
                    w_count_next = 32'd0;
                end
            endcase
        end
    end

    // Output logic: report / timeout events and the lock decision.
    always_comb begin
        w_diff = (r_count >= r_prev) ? (r_count - r_prev)
                                     : (r_prev - r_count);
        // prev_period of zero means no earlier period to compare against.
        w_match  = (r_prev != 32'd0) && (w_diff <= TOL);
        w_report = sample_valid && (r_state == ST_MEASURE) && w_rise;
        w_expire = sample_valid && (r_state == ST_MEASURE) && !w_rise &&
                   (w_count_inc == MAX_P);
        w_locked_next = r_locked;
        if (w_report) begin
            w_locked_next = w_match;
        end else if (w_expire) begin
            w_locked_next = 1'b0;
        end
    end

    assign wave_length       = r_wave_length;
    assign wave_length_valid = r_wlv;
    assign locked            = r_locked;
    assign timeout           = r_timeout;

endmodule

// File: tb/tb_period_detector.sv
// Scoreboard bench for period_detector: stimulus pushes expected pulses
// (kind, cycle, wave_length, locked); a negedge monitor pops and compares.
module tb_period_detector;

    localparam int MAXP = 1000;
    localparam int HI   = 1000000;
    localparam int LO   = -1000000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] sample = 32'd0;
    logic [31:0] wave_length;
    logic        wave_length_valid;
    logic        locked;
    logic        timeout;

    period_detector #(
        .SAMPLE_WIDTH(32),
        .HYSTERESIS  (4096),
        .MAX_PERIOD  (MAXP),
        .TOLERANCE   (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .sample_valid     (sample_valid),
        .sample           (sample),
        .wave_length      (wave_length),
        .wave_length_valid(wave_length_valid),
        .locked           (locked),
        .timeout          (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_to;
        int wl;
        bit lk;
        int at;
    } exp_t;

    typedef struct {
        int p;
        bit rep;
        int wl;
        bit lk;
    } per_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input longint act,
                       input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)",
                     name, act, want, cyc);
        end
    endtask

    task automatic push(input bit is_to, input int wl, input bit lk,
                        input int at);
        exp_t x;
        x.is_to = is_to;
        x.wl    = wl;
        x.lk    = lk;
        x.at    = at;
        q.push_back(x);
    endtask

    // Drive one sample; it is consumed at the next rising edge.
    task automatic put(input int v, input bit vld);
        sample       = v;
        sample_valid = vld;
        @(posedge clk);
        #1;
    endtask

    // One square period, high half first, so each call starts with a
    // rising crossing. rep/wl/lk describe the report on that crossing.
    task automatic sq(input int p, input bit rep, input int wl,
                      input bit lk, input bit alt);
        for (int i = 0; i < p; i++) begin
            int v;
            v = (i < p / 2) ? HI : LO;
            if (i == 0 && rep) push(1'b0, wl, lk, cyc + 1);
            put(v, 1'b1);
            if (alt) put(-v, 1'b0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wave_length"}, wave_length, 0);
        chk({tag, "_wlv"}, wave_length_valid, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (wave_length_valid || timeout) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse cycle %0d wlv %0b timeout %0b wl %0d",
                             cyc, wave_length_valid, timeout, wave_length);
                end else begin
                    e = q.pop_front();
                    chk("pulse_cycle", cyc, e.at);
                    chk("pulse_timeout", timeout, e.is_to);
                    chk("pulse_wlv", wave_length_valid, !e.is_to);
                    chk("pulse_wave_length", wave_length, e.wl);
                    chk("pulse_locked", locked, e.lk);
                end
            end else if (q.size() != 0 && q[0].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse got none want at cycle %0d (now %0d)",
                         q[0].at, cyc);
                void'(q.pop_front());
            end
        end
    end

    per_t tab[12] = '{
        '{100, 1'b0,   0, 1'b0},
        '{100, 1'b1, 100, 1'b0},
        '{100, 1'b1, 100, 1'b1},
        '{100, 1'b1, 100, 1'b1},
        '{200, 1'b1, 100, 1'b1},
        '{200, 1'b1, 200, 1'b0},
        '{200, 1'b1, 200, 1'b1},
        '{100, 1'b1, 200, 1'b1},
        '{100, 1'b1, 100, 1'b0},
        '{100, 1'b1, 100, 1'b1},
        '{101, 1'b1, 100, 1'b1},
        '{101, 1'b1, 101, 1'b1}
    };

    initial begin
        int c;
        #3;
        chk_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Square 100, period switches, 100 -> 101 within tolerance.
        for (int i = 0; i < 10; i++) put(LO, 1'b1);
        for (int i = 0; i < 12; i++)
            sq(tab[i].p, tab[i].rep, tab[i].wl, tab[i].lk, 1'b0);

        // Async reset mid-period while locked.
        push(1'b0, 101, 1'b1, cyc + 1);
        put(HI, 1'b1);
        for (int i = 0; i < 30; i++) put(HI, 1'b1);
        chk("locked_before_reset", locked, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(posedge clk);
        #1;
        put(LO, 1'b1);
        put(HI, 1'b1);
        reset_n = 1'b1;

        // Valid every other clock, square 50; invalid cycles carry the
        // opposite polarity and must be ignored.
        for (int i = 0; i < 6; i++) begin
            put(LO, 1'b1);
            put(HI, 1'b0);
        end
        sq(50, 1'b0, 0, 1'b0, 1'b1);
        sq(50, 1'b1, 50, 1'b0, 1'b1);
        sq(50, 1'b1, 50, 1'b1, 1'b1);

        // Last crossing, then in-band noise until timeout.
        push(1'b0, 50, 1'b1, cyc + 1);
        c = cyc;
        put(HI, 1'b1);
        push(1'b1, 50, 1'b0, c + MAXP);
        for (int k = 0; k < MAXP + 20; k++)
            put((k % 2 == 0) ? 100 : -100, 1'b1);

        // Back in SEEK: first crossing silent; crossing on the sample that
        // would reach MAX_PERIOD reports MAXP-1 and no timeout.
        for (int i = 0; i < 5; i++) put(LO, 1'b1);
        put(HI, 1'b1);
        for (int j = 1; j <= MAXP - 2; j++) put(LO, 1'b1);
        push(1'b0, MAXP - 1, 1'b0, cyc + 1);
        put(HI, 1'b1);
        for (int i = 0; i < 10; i++) put(LO, 1'b1);

        reset_n = 1'b0;
        #1;
        chk_zero("reset2");
        put(LO, 1'b1);
        reset_n = 1'b1;

        // Saw ramp, period 480; first sample above +4096 is index 241.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 480; i++) begin
                int v;
                v = LO + (i * 2000000) / 479;
                if (i == 241 && k >= 1) push(1'b0, 480, k >= 2, cyc + 1);
                put(v, 1'b1);
            end
        end

        for (int i = 0; i < 5; i++) put(0, 1'b0);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
